// File: rtl/wsg_mix_receiver.sv
// WSG 8-slot DAC byte demultiplexer, volume mixer and PCM sample FIFO.

// Generic show-ahead FIFO, pop_dat valid whenever pop_vld.
// Latency: a push is visible at pop_dat one edge later.
// Backpressure: push_rdy drops when full unless a pop frees the slot on the same edge.
module wsg_mix_fifo #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          pxclk,
    input  logic          RESET,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    output logic          push_rdy,
    output logic          pop_vld,
    output logic [DW-1:0] pop_dat,
    input  logic          pop_rdy
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_vld  = (count != '0);
    assign do_pop   = pop_vld & pop_rdy;
    assign push_rdy = ~full | do_pop;
    assign do_push  = push_vld & push_rdy;
    assign pop_dat  = mem[rd_ptr];

    // Storage needs no reset; count gates every read.
    always_ff @(posedge pxclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Demuxes the WSG byte stream, mixes 8 volume-scaled slots into one 16-bit sample per frame.
// Latency: sample enters the FIFO on the edge after the slot-7 capture edge.
// Backpressure: pcm_valid/pcm_ready; a frame arriving at a full FIFO is dropped and flagged.
module wsg_mix_receiver #(
    parameter int SAMPLE_PHASE = 12,
    parameter int SHIFT        = 5,
    parameter int FIFO_AW      = 2
) (
    input  logic        pxclk,
    input  logic        RESET,
    input  logic [7:0]  c99raw_in,
    input  logic [7:0]  ch_enable,
    input  logic        ovf_clr,
    input  logic        pcm_ready,
    output logic [15:0] pcm_out,
    output logic        pcm_valid,
    output logic        frame_tick,
    output logic        overflow
);
    logic [6:0]         phase;
    logic [2:0]         slot;
    logic               capture;
    logic               frame_end;
    logic signed [7:0]  vol_s;
    logic signed [7:0]  wave_s;
    logic signed [7:0]  term_raw;
    logic signed [7:0]  term;
    logic signed [10:0] term_ext;
    logic signed [10:0] acc;
    logic signed [10:0] acc_sum;
    logic signed [10:0] frame_sum;
    logic               push_stb;
    logic signed [19:0] sum_ext;
    logic signed [19:0] shifted;
    logic [15:0]        sample;
    logic               push_rdy;
    logic [15:0]        head_dat;
    logic               drop;

    assign slot      = phase[6:4];
    assign capture   = (phase[3:0] == 4'(SAMPLE_PHASE));
    assign frame_end = capture & (slot == 3'd7);

    // Wave nibble is offset-binary around 8; 8-bit product is exact for 4b x 5b signed.
    assign vol_s    = {4'b0000, c99raw_in[7:4]};
    assign wave_s   = {4'b0000, c99raw_in[3:0]} - 8'sd8;
    assign term_raw = vol_s * wave_s;
    assign term     = ch_enable[slot] ? term_raw : 8'sd0;
    assign term_ext = {{3{term[7]}}, term};
    assign acc_sum  = acc + term_ext;

    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            phase      <= '0;
            acc        <= '0;
            frame_sum  <= '0;
            push_stb   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            phase      <= phase + 1'b1;
            push_stb   <= frame_end;
            frame_tick <= frame_end;
            if (capture) begin
                acc <= (slot == 3'd0) ? term_ext : acc_sum;
            end
            if (frame_end) begin
                frame_sum <= acc_sum;
            end
        end
    end

    // Widen far enough that the largest shift cannot wrap before saturation.
    assign sum_ext = {{9{frame_sum[10]}}, frame_sum};
    assign shifted = sum_ext <<< SHIFT;

    always_comb begin
        sample = shifted[15:0];
        if (shifted > 20'sd32767) begin
            sample = 16'h7FFF;
        end else if (shifted < -20'sd32768) begin
            sample = 16'h8000;
        end
    end

    wsg_mix_fifo #(
        .DW (16),
        .AW (FIFO_AW)
    ) u_fifo (
        .pxclk    (pxclk),
        .RESET    (RESET),
        .push_vld (push_stb),
        .push_dat (sample),
        .push_rdy (push_rdy),
        .pop_vld  (pcm_valid),
        .pop_dat  (head_dat),
        .pop_rdy  (pcm_ready)
    );

    assign pcm_out = pcm_valid ? head_dat : 16'h0000;
    assign drop    = push_stb & ~push_rdy;

    // A drop on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge pxclk or posedge RESET) begin
        if (RESET) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wsg_mix_receiver.sv
// Bench for wsg_mix_receiver: fixed-pattern vector table, FIFO/reset sequences, random frames vs a queue model.
module tb_wsg_mix_receiver;
    logic        pxclk = 1'b0;
    logic        RESET;
    logic [7:0]  c99raw_in;
    logic [7:0]  ch_enable;
    logic        ovf_clr;
    logic        pcm_ready;
    logic [15:0] pcm_out;
    logic        pcm_valid;
    logic        frame_tick;
    logic        overflow;
    logic [15:0] pcm_out6;
    logic        pcm_valid6;
    logic        frame_tick6;
    logic        overflow6;

    always #5 pxclk = ~pxclk;

    wsg_mix_receiver #(.SAMPLE_PHASE(12), .SHIFT(5), .FIFO_AW(2)) dut (
        .pxclk(pxclk), .RESET(RESET), .c99raw_in(c99raw_in), .ch_enable(ch_enable),
        .ovf_clr(ovf_clr), .pcm_ready(pcm_ready), .pcm_out(pcm_out),
        .pcm_valid(pcm_valid), .frame_tick(frame_tick), .overflow(overflow)
    );

    wsg_mix_receiver #(.SAMPLE_PHASE(12), .SHIFT(6), .FIFO_AW(2)) dut6 (
        .pxclk(pxclk), .RESET(RESET), .c99raw_in(c99raw_in), .ch_enable(ch_enable),
        .ovf_clr(ovf_clr), .pcm_ready(pcm_ready), .pcm_out(pcm_out6),
        .pcm_valid(pcm_valid6), .frame_tick(frame_tick6), .overflow(overflow6)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: frame sums queued as plain integers.
    int         cur_phase;
    int         q[$];
    bit         pend;
    int         pend_sum;
    bit         ovf_m;
    bit         tick_m;
    bit         pushed_now;
    int         terms[8];
    logic [7:0] pat[8];

    typedef struct {
        string      name;
        logic [7:0] base;
        bit         per_slot;
        logic [7:0] en;
        logic [15:0] exp5;
        logic [15:0] exp6;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int term_of(input logic [7:0] b, input logic en);
        if (!en) return 0;
        return int'(b[7:4]) * (int'(b[3:0]) - 8);
    endfunction

    function automatic logic [15:0] sat(input int sum, input int sh);
        int v;
        v = sum * (1 << sh);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic model_reset();
        q.delete();
        pend = 0;
        pend_sum = 0;
        ovf_m = 0;
        tick_m = 0;
        cur_phase = 0;
        foreach (terms[i]) terms[i] = 0;
    endtask

    // One pxclk: drive the slot byte, step the model across the edge, compare outputs.
    task automatic tick();
        bit pop;
        bit push;
        bit drop;
        bit fe;
        int s;
        pop = 0; push = 0; drop = 0; fe = 0;
        c99raw_in = pat[cur_phase / 16];
        pushed_now = 0;
        if (!RESET) begin
            if (cur_phase % 16 == 12)
                terms[cur_phase / 16] = term_of(c99raw_in, ch_enable[cur_phase / 16]);
            fe   = (cur_phase == 'h7C);
            pop  = (q.size() > 0) && pcm_ready;
            push = pend;
            drop = push && (q.size() == 4) && !pop;
        end
        @(posedge pxclk);
        #1;
        if (RESET) begin
            model_reset();
        end else begin
            if (pop) void'(q.pop_front());
            if (push && !drop) begin
                q.push_back(pend_sum);
                pushed_now = 1;
            end
            if (drop) ovf_m = 1;
            else if (ovf_clr) ovf_m = 0;
            pend = fe;
            if (fe) begin
                s = 0;
                foreach (terms[i]) s += terms[i];
                pend_sum = s;
            end
            tick_m = fe;
            cur_phase = (cur_phase + 1) % 128;
        end
        chk("pcm_valid", pcm_valid, q.size() != 0);
        chk("pcm_valid6", pcm_valid6, q.size() != 0);
        if (q.size() != 0) begin
            chk("pcm_out", pcm_out, sat(q[0], 5));
            chk("pcm_out6", pcm_out6, sat(q[0], 6));
        end
        chk("frame_tick", frame_tick, tick_m);
        chk("overflow", overflow, ovf_m);
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 200 && cur_phase != ph; k++) tick();
    endtask

    // After reset release: edges to first frame_tick and first pcm_valid, then the sample period.
    task automatic timing_run(input string tag);
        int n;
        int saw_tick;
        n = 0;
        saw_tick = -1;
        while (!pcm_valid && n < 300) begin
            tick();
            n++;
            if (frame_tick && saw_tick < 0) saw_tick = n;
        end
        chk({tag, "_tick_edge"}, 16'(saw_tick), 16'd125);
        chk({tag, "_valid_edge"}, 16'(n), 16'd126);
        chk({tag, "_value"}, pcm_out, 16'h6900);
        chk({tag, "_value6"}, pcm_out6, 16'h7FFF);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pcm_valid && n < 300);
        chk({tag, "_period"}, 16'(n), 16'd128);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int nq;
        int expq[$];
        vecs[0] = '{"all_ff",    8'hFF, 1'b0, 8'hFF, 16'h6900, 16'h7FFF};
        vecs[1] = '{"all_f0",    8'hF0, 1'b0, 8'hFF, 16'h8800, 16'h8000};
        vecs[2] = '{"vol0",      8'h0F, 1'b0, 8'hFF, 16'h0000, 16'h0000};
        vecs[3] = '{"en_01",     8'hFF, 1'b0, 8'h01, 16'h0D20, 16'h1A40};
        vecs[4] = '{"per_slot",  8'hF0, 1'b1, 8'hFF, 16'hBC80, 16'h8000};
        vecs[5] = '{"mid_wave",  8'h88, 1'b0, 8'hFF, 16'h0000, 16'h0000};
        vecs[6] = '{"vol1_w1",   8'h19, 1'b0, 8'hFF, 16'h0100, 16'h0200};
        vecs[7] = '{"en_aa",     8'hF7, 1'b0, 8'hAA, 16'hF880, 16'hF100};
        vecs[8] = '{"en_0f",     8'h3A, 1'b0, 8'h0F, 16'h0300, 16'h0600};

        RESET = 1'b1;
        c99raw_in = 8'h00;
        ch_enable = 8'hFF;
        ovf_clr = 1'b0;
        pcm_ready = 1'b1;
        foreach (pat[i]) pat[i] = 8'hFF;
        model_reset();
        repeat (3) @(posedge pxclk);
        #1;
        chk("rst_pcm_out", pcm_out, 16'h0000);
        chk("rst_pcm_valid", pcm_valid, 1'b0);
        chk("rst_frame_tick", frame_tick, 1'b0);
        chk("rst_overflow", overflow, 1'b0);

        RESET = 1'b0;
        timing_run("s1");

        foreach (vecs[v]) begin
            wait_phase(0);
            ch_enable = vecs[v].en;
            foreach (pat[s]) pat[s] = vecs[v].per_slot ? (vecs[v].base | 8'(s)) : vecs[v].base;
            nq = 0;
            do begin
                tick();
                nq++;
            end while (!pushed_now && nq < 200);
            chk({vecs[v].name, "_s5"}, pcm_out, vecs[v].exp5);
            chk({vecs[v].name, "_s6"}, pcm_out6, vecs[v].exp6);
        end

        // FIFO full, fifth frame dropped, clear, drain in order.
        wait_phase(0);
        ch_enable = 8'hFF;
        pcm_ready = 1'b0;
        for (int f = 0; f < 5; f++) begin
            foreach (pat[s]) pat[s] = 8'($urandom_range(0, 255));
            pat[0] = {4'hF, 4'(f)};
            repeat (128) tick();
        end
        chk("s5_overflow", overflow, 1'b1);
        chk("s5_full_valid", pcm_valid, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("s5_ovf_cleared", overflow, 1'b0);
        expq = q;
        pcm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("s5_drain", pcm_out, sat((i < expq.size()) ? expq[i] : 99999, 5));
            tick();
        end
        chk("s5_drained", pcm_valid, 1'b0);

        // Full FIFO with a pop on the push edge: no drop.
        pcm_ready = 1'b0;
        for (int k = 0; k < 1000 && q.size() < 4; k++) tick();
        wait_phase('h7D);
        pcm_ready = 1'b1;
        tick();
        pcm_ready = 1'b0;
        chk("s5_push_pop_ovf", overflow, 1'b0);
        chk("s5_push_pop_valid", pcm_valid, 1'b1);

        // Reset mid-frame with two entries queued.
        pcm_ready = 1'b1;
        tick();
        tick();
        pcm_ready = 1'b0;
        wait_phase('h45);
        chk("s6_phase_reached", 16'(cur_phase), 16'h0045);
        chk("s6_two_queued", pcm_valid, 1'b1);
        RESET = 1'b1;
        model_reset();
        #1;
        chk("s6_rst_pcm_out", pcm_out, 16'h0000);
        chk("s6_rst_valid", pcm_valid, 1'b0);
        chk("s6_rst_tick", frame_tick, 1'b0);
        chk("s6_rst_ovf", overflow, 1'b0);
        tick();
        tick();
        RESET = 1'b0;
        pcm_ready = 1'b1;
        ch_enable = 8'hFF;
        foreach (pat[s]) pat[s] = 8'hFF;
        timing_run("s6");

        // Random frames, enables, backpressure and clears against the model.
        for (int f = 0; f < 20; f++) begin
            foreach (pat[s]) pat[s] = 8'($urandom_range(0, 255));
            for (int c = 0; c < 128; c++) begin
                ch_enable = 8'($urandom_range(0, 255));
                pcm_ready = (f < 10) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
                ovf_clr = ($urandom_range(0, 63) == 0);
                tick();
            end
        end
        ovf_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
